// File: rtl/hc32_tst_pkg.sv
// Shared types and helpers for the HC32 quad OR-gate pin tester.
package hc32_tst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NGATE_DEF = 4;
    localparam int VEC_W     = 2 * NGATE_DEF;

    // Reference OR; callers zero-extend, so one width fits any gate count.
    function automatic logic [31:0] or_ref(input logic [31:0] a, input logic [31:0] b);
        return a | b;
    endfunction

endpackage

// File: rtl/hc32_pin_tester_sync_2ff.sv
// Two-flop synchronizer for the sensed Y pins.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hc32_pin_tester.sv
// HC32 quad OR-gate pin tester: sweeps all A/B vectors and checks Y = A | B.
// Optional build macro: HC32_TST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module hc32_pin_tester
    import hc32_tst_pkg::*;
#(
    parameter int NGATE      = NGATE_DEF,
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [NGATE-1:0]   drv_a,
    output logic [NGATE-1:0]   drv_b,
    input  logic [NGATE-1:0]   sns_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*NGATE:0]   err_cnt,
    output logic [2*NGATE-1:0] fail_vec,
    output logic [NGATE-1:0]   fail_y
);

    localparam int VW = 2 * NGATE;
    localparam int EW = 2 * NGATE + 1;

    localparam logic [VW-1:0] VEC_ONE    = VW'(1);
    localparam logic [EW-1:0] ERR_ONE    = EW'(1);
    localparam logic [7:0]    SETTLE_LDV = 8'(SETTLE_CYC - 1);

    state_t          state;
    state_t          state_nx;
    logic [VW-1:0]   vec;
    logic [7:0]      settle_cnt;
    logic [NGATE-1:0] y_sync;
    logic            mismatch;
    logic            stop_fail;
    logic            run_go;

    sync_2ff #(
        .W(NGATE)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sns_y),
        .q    (y_sync)
    );

    assign mismatch = (32'(y_sync) != or_ref(32'(drv_a), 32'(drv_b)));

`ifdef HC32_TST_STOP_ON_FAIL_EN
    assign stop_fail = mismatch;
`else
    assign stop_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        run_go   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = DRIVE;
                    run_go   = 1'b1;
                end
            end
            DRIVE:  state_nx = SETTLE;
            SETTLE: if (settle_cnt == 8'd0) state_nx = SAMPLE;
            SAMPLE: begin
                if (stop_fail || (&vec)) state_nx = DONE;
                else                     state_nx = DRIVE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            drv_a      <= '0;
            drv_b      <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_y     <= '0;
        end else begin
            if (run_go) begin
                vec      <= '0;
                err_cnt  <= '0;
                fail_vec <= '0;
                fail_y   <= '0;
            end
            case (state)
                DRIVE: begin
                    drv_a      <= vec[NGATE-1:0];
                    drv_b      <= vec[VW-1:NGATE];
                    settle_cnt <= SETTLE_LDV;
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
                        // Only the first failing vector is recorded.
                        if (err_cnt == '0) begin
                            fail_vec <= vec;
                            fail_y   <= y_sync;
                        end
                    end
                    if (state_nx == DRIVE) vec <= vec + VEC_ONE;
                end
                DONE: begin
                    drv_a <= '0;
                    drv_b <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

endmodule
